// File: rtl/dual_rail_xor_engine.sv
// dual_rail_xor_engine
//   Pipelined dual-rail XOR encryption engine. Each beat carries NUM_LANES
//   lanes of LANE_WIDTH-bit dual-rail plaintext (x/x_bar) and key (k/k_bar).
//   The key comes from the beat itself or from a stored key register.
//   The result is s = x ^ key with s_bar = ~s.
//   Any lane whose inputs break the dual-rail encoding is flagged and
//   forced to the all-zero spacer.
//
//   Pipeline: stage 1 registers the operands and the selected key.
//   Stage 2 is the output register bank.
//   A beat accepted at edge N is presented on out_valid after edge N+1.
//   Throughput is one beat per cycle.
//
// Ports
//   wb_clk_i              clock, rising edge
//   wb_rst_i              synchronous active-high reset
//   VDD, GND              power pins (USE_POWER_PINS only)
//   in_valid / in_ready   input handshake
//   x, x_bar              dual-rail plaintext, lane i at [i*LANE_WIDTH +: LANE_WIDTH]
//   k, k_bar              dual-rail beat key, also the key-register load source
//   key_mode              0: beat key, 1: stored key (sampled at acceptance)
//   key_load              captures k/k_bar into the key register
//   out_valid / out_ready output handshake
//   s, s_bar              dual-rail result
//   lane_err              per-lane encoding violation, aligned with s
//   err_count             saturating count of transferred beats with any lane_err
module dual_rail_xor_engine #(
  parameter int LANE_WIDTH    = 4,
  parameter int NUM_LANES     = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
`ifdef USE_POWER_PINS
  inout  wire                              VDD,
  inout  wire                              GND,
`endif
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANE_WIDTH*NUM_LANES-1:0]  x,
  input  logic [LANE_WIDTH*NUM_LANES-1:0]  x_bar,
  input  logic [LANE_WIDTH*NUM_LANES-1:0]  k,
  input  logic [LANE_WIDTH*NUM_LANES-1:0]  k_bar,
  input  logic                             key_mode,
  input  logic                             key_load,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANE_WIDTH*NUM_LANES-1:0]  s,
  output logic [LANE_WIDTH*NUM_LANES-1:0]  s_bar,
  output logic [NUM_LANES-1:0]             lane_err,
  output logic [ERR_CNT_WIDTH-1:0]         err_count
);

  localparam int W = LANE_WIDTH * NUM_LANES;

  logic         s1_valid;
  logic [W-1:0] s1_x;
  logic [W-1:0] s1_x_bar;
  logic [W-1:0] s1_k;
  logic [W-1:0] s1_k_bar;

  logic [W-1:0] key_reg;
  logic [W-1:0] key_bar_reg;

  logic         s2_load;
  logic         accept;

  logic [W-1:0]         s_nxt;
  logic [W-1:0]         s_bar_nxt;
  logic [NUM_LANES-1:0] lane_bad;

  // Stage 2 frees up when empty or when its beat leaves this cycle; stage 1
  // can then always move forward, so that is also when a new beat fits.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;

  // A valid dual-rail pair has every bit of the true rail differing from
  // the complement rail; a single equal bit poisons the whole lane.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [LANE_WIDTH-1:0] sum;

    assign sum = s1_x[i*LANE_WIDTH +: LANE_WIDTH] ^ s1_k[i*LANE_WIDTH +: LANE_WIDTH];

    assign lane_bad[i] =
      ~&(s1_x[i*LANE_WIDTH +: LANE_WIDTH] ^ s1_x_bar[i*LANE_WIDTH +: LANE_WIDTH]) |
      ~&(s1_k[i*LANE_WIDTH +: LANE_WIDTH] ^ s1_k_bar[i*LANE_WIDTH +: LANE_WIDTH]);

    assign s_nxt[i*LANE_WIDTH +: LANE_WIDTH]     = lane_bad[i] ? '0 : sum;
    assign s_bar_nxt[i*LANE_WIDTH +: LANE_WIDTH] = lane_bad[i] ? '0 : ~sum;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      key_reg     <= '0;
      key_bar_reg <= '1;
      s1_valid    <= 1'b0;
      s1_x        <= '0;
      s1_x_bar    <= '0;
      s1_k        <= '0;
      s1_k_bar    <= '0;
      out_valid   <= 1'b0;
      s           <= '0;
      s_bar       <= '0;
      lane_err    <= '0;
      err_count   <= '0;
    end else begin
      // A beat accepted together with key_load still sees the old key here,
      // because key_reg only changes at the end of this edge.
      if (key_load) begin
        key_reg     <= k;
        key_bar_reg <= k_bar;
      end

      if (in_ready) begin
        s1_valid <= in_valid;
      end

      if (accept) begin
        s1_x     <= x;
        s1_x_bar <= x_bar;
        s1_k     <= key_mode ? key_reg : k;
        s1_k_bar <= key_mode ? key_bar_reg : k_bar;
      end

      // Output data only moves when a real beat arrives so a bubble does not
      // disturb the last result.
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          s        <= s_nxt;
          s_bar    <= s_bar_nxt;
          lane_err <= lane_bad;
        end
      end

      if (out_valid && out_ready && (|lane_err) && (err_count != '1)) begin
        err_count <= err_count + ERR_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_dual_rail_xor_engine.sv
module tb_dual_rail_xor_engine;

  localparam int LW = 4;
  localparam int NL = 4;
  localparam int W  = LW * NL;
  localparam int EW = 4;

  typedef struct packed {
    logic [W-1:0]  s;
    logic [W-1:0]  sb;
    logic [NL-1:0] e;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  x = '0, x_bar = '1, k = '0, k_bar = '1;
  logic          key_mode = 1'b0;
  logic          key_load = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  s, s_bar;
  logic [NL-1:0] lane_err;
  logic [EW-1:0] err_count;

  int total = 0;
  int bad   = 0;

  exp_t          q[$];
  logic [W-1:0]  mk  = '0;
  logic [W-1:0]  mkb = '1;
  logic [EW-1:0] model_cnt = '0;
  logic          last_acc = 1'b0;
  int            acc_cnt  = 0;
  int            xfer_cnt = 0;

  always #5 clk = ~clk;

  dual_rail_xor_engine #(
    .LANE_WIDTH(LW), .NUM_LANES(NL), .ERR_CNT_WIDTH(EW)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .x_bar(x_bar), .k(k), .k_bar(k_bar),
    .key_mode(key_mode), .key_load(key_load),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .s_bar(s_bar), .lane_err(lane_err), .err_count(err_count)
  );

  function automatic exp_t model(input logic [W-1:0] xv, xbv, kv, kbv);
    exp_t r;
    logic bad_lane;
    r = '0;
    for (int l = 0; l < NL; l++) begin
      bad_lane = 1'b0;
      for (int b = 0; b < LW; b++)
        if (xv[l*LW+b] == xbv[l*LW+b] || kv[l*LW+b] == kbv[l*LW+b]) bad_lane = 1'b1;
      r.e[l] = bad_lane;
      for (int b = 0; b < LW; b++) begin
        r.s[l*LW+b]  = bad_lane ? 1'b0 : (xv[l*LW+b] ^ kv[l*LW+b]);
        r.sb[l*LW+b] = bad_lane ? 1'b0 : ~(xv[l*LW+b] ^ kv[l*LW+b]);
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples mid-cycle, updates the scoreboard and model, then crosses one
  // rising edge and returns 1 time unit after it.
  task automatic tick();
    logic acc, xfer;
    #2;
    acc  = 1'b0;
    xfer = 1'b0;
    if (!rst) begin
      chk("err_count", 64'(err_count), 64'(model_cnt));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          chk("s", 64'(s), 64'(q[0].s));
          chk("s_bar", 64'(s_bar), 64'(q[0].sb));
          chk("lane_err", 64'(lane_err), 64'(q[0].e));
        end
      end
      xfer = out_valid && out_ready;
      acc  = in_valid && in_ready;
      if (acc) begin
        q.push_back(key_mode ? model(x, x_bar, mk, mkb) : model(x, x_bar, k, k_bar));
        acc_cnt++;
      end
      if (key_load) begin
        mk  = k;
        mkb = k_bar;
      end
      if (xfer) begin
        xfer_cnt++;
        if (q.size() != 0) begin
          if (q[0].e != '0 && model_cnt != '1) model_cnt = model_cnt + 1'b1;
          void'(q.pop_front());
        end
      end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      mk        = '0;
      mkb       = '1;
      model_cnt = '0;
    end
  endtask

  task automatic set_beat(input logic [W-1:0] xv, xbv, kv, kbv, input logic mode);
    x = xv; x_bar = xbv; k = kv; k_bar = kbv; key_mode = mode;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 30 && q.size() != 0; i++) tick();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int a0, x0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_s_bar", 64'(s_bar), 64'd0);
    chk("rst_lane_err", 64'(lane_err), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    rst = 1'b0;
    tick();

    // Single beat, beat key, latency
    out_ready = 1'b1;
    set_beat(16'h1234, 16'hEDCB, 16'h00FF, 16'hFF00, 1'b0);
    in_valid = 1'b1;
    tick();
    chk("single_acc", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
    chk("lat_n1", 64'(out_valid), 64'd0);
    tick();
    chk("lat_n2", 64'(out_valid), 64'd1);
    chk("single_s", 64'(s), 64'h12CB);
    chk("single_s_bar", 64'(s_bar), 64'hED34);
    chk("single_err", 64'(lane_err), 64'd0);
    drain();
    chk("single_cnt", 64'(err_count), 64'd0);

    // Stored key: same-cycle load uses old (zero) key, next beat the new key
    set_beat(16'hFFFF, 16'h0000, 16'hA5A5, 16'h5A5A, 1'b1);
    key_load = 1'b1;
    in_valid = 1'b1;
    tick();
    key_load = 1'b0;
    k = 16'h0000; k_bar = 16'h0000;
    tick();
    in_valid = 1'b0;
    chk("key_old", 64'(s), 64'hFFFF);
    tick();
    chk("key_new", 64'(s), 64'h5A5A);
    drain();

    // Integrity violation in lane 0
    set_beat(16'h0001, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("int_lane_err", 64'(lane_err), 64'h1);
    chk("int_s", 64'(s), 64'h00F0);
    chk("int_s_bar", 64'(s_bar), 64'hFF00);
    tick();
    chk("int_cnt", 64'(err_count), 64'd1);
    drain();

    // Backpressure: 5 beats with out_ready low, then release
    out_ready = 1'b0;
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      set_beat(16'h0F00 + 16'(acc_cnt - a0), ~(16'h0F00 + 16'(acc_cnt - a0)),
               16'h3C3C, 16'hC3C3, 1'b0);
      in_valid = 1'b1;
      tick();
      if (i == 1) begin
        chk("bp_acc2", 64'(acc_cnt - a0), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
    end
    out_ready = 1'b1;
    x0 = xfer_cnt;
    for (int i = 0; i < 5; i++) begin
      if (acc_cnt - a0 < 5) begin
        set_beat(16'h0F00 + 16'(acc_cnt - a0), ~(16'h0F00 + 16'(acc_cnt - a0)),
                 16'h3C3C, 16'hC3C3, 1'b0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("bp_all_acc", 64'(acc_cnt - a0), 64'd5);
    chk("bp_rate", 64'(xfer_cnt - x0), 64'd5);
    drain();

    // Saturation of the 4-bit error counter
    set_beat(16'h0001, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b0);
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      tick();
    end
    drain();
    tick();
    chk("sat_cnt", 64'(err_count), 64'hF);

    // Reset with both stages full
    out_ready = 1'b0;
    set_beat(16'h1357, 16'hECA8, 16'h0F0F, 16'hF0F0, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_err_count", 64'(err_count), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    set_beat(16'h1234, 16'hEDCB, 16'h0000, 16'h0000, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rst_key_zero", 64'(s), 64'h1234);
    drain();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
